alu_ctrl_exec: RTL and testbench

ALU_CTRL_EXEC -- requirements
Module: alu_ctrl_exec

---
 rtl/alu_ctrl_exec.sv | 192 +++++++++++++++++++
 tb/tb_alu_ctrl_exec.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_exec
// Description : RV32-style ALU control decode and execute unit with a
//               valid/ready handshake and an optional bit-serial shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_exec #(
   parameter int XLEN         = 32,
   parameter bit SERIAL_SHIFT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      modo,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [3:0]      sel_alu,
   output logic            branch_taken,
   output logic            illegal
);

   localparam int c_SH = $clog2(XLEN);
   localparam logic [c_SH-1:0] c_ONE = c_SH'(1);

   localparam logic [3:0] c_ADD  = 4'd0;
   localparam logic [3:0] c_SUB  = 4'd1;
   localparam logic [3:0] c_SLL  = 4'd2;
   localparam logic [3:0] c_SLT  = 4'd3;
   localparam logic [3:0] c_SLTU = 4'd4;
   localparam logic [3:0] c_XOR  = 4'd5;
   localparam logic [3:0] c_SRL  = 4'd6;
   localparam logic [3:0] c_SRA  = 4'd7;
   localparam logic [3:0] c_OR   = 4'd8;
   localparam logic [3:0] c_AND  = 4'd9;
   localparam logic [3:0] c_EQ   = 4'd10;
   localparam logic [3:0] c_NE   = 4'd11;
   localparam logic [3:0] c_LT   = 4'd12;
   localparam logic [3:0] c_GE   = 4'd13;
   localparam logic [3:0] c_LTU  = 4'd14;
   localparam logic [3:0] c_GEU  = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state, w_state_next;
   logic [XLEN-1:0]   r_result;
   logic [3:0]        r_sel;
   logic              r_taken;
   logic              r_illegal;
   logic [c_SH-1:0]   r_cnt;

   logic [3:0]        w_sel;
   logic              w_illegal;
   logic [XLEN-1:0]   w_alu;
   logic              w_taken;
   logic              w_is_shift;
   logic              w_serial;
   logic [c_SH-1:0]   w_shamt;
   logic              w_accept;
   logic              w_unused_funct7;

   assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};
   assign w_shamt         = op_b[c_SH-1:0];
   assign w_accept        = in_valid && (r_state == S_IDLE);

   always_comb begin
      w_sel     = c_ADD;
      w_illegal = 1'b0;
      unique case (modo)
         2'b00: w_sel = c_ADD;
         2'b01, 2'b10: begin
            unique case (funct3)
               3'b000: w_sel = (modo == 2'b10 && funct7[5]) ? c_SUB : c_ADD;
               3'b001: w_sel = c_SLL;
               3'b010: w_sel = c_SLT;
               3'b011: w_sel = c_SLTU;
               3'b100: w_sel = c_XOR;
               3'b101: w_sel = funct7[5] ? c_SRA : c_SRL;
               3'b110: w_sel = c_OR;
               default: w_sel = c_AND;
            endcase
            // Register-register ops only allow funct7[5] on ADD/SUB and SRL/SRA
            if (modo == 2'b10 && funct7[5] && funct3 != 3'b000 && funct3 != 3'b101) begin
               w_illegal = 1'b1;
               w_sel     = c_ADD;
            end
         end
         default: begin
            unique case (funct3)
               3'b000: w_sel = c_EQ;
               3'b001: w_sel = c_NE;
               3'b100: w_sel = c_LT;
               3'b101: w_sel = c_GE;
               3'b110: w_sel = c_LTU;
               3'b111: w_sel = c_GEU;
               default: w_illegal = 1'b1;
            endcase
         end
      endcase
   end

   // With the serial shifter, shift results come from the SHIFT state, so
   // the single-cycle path only needs the shamt==0 case (result = op_a).
   always_comb begin
      w_alu = '0;
      unique case (w_sel)
         c_ADD:  w_alu = op_a + op_b;
         c_SUB:  w_alu = op_a - op_b;
         c_SLL:  w_alu = SERIAL_SHIFT ? op_a : (op_a << w_shamt);
         c_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         c_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         c_XOR:  w_alu = op_a ^ op_b;
         c_SRL:  w_alu = SERIAL_SHIFT ? op_a : (op_a >> w_shamt);
         c_SRA:  w_alu = SERIAL_SHIFT ? op_a : ($signed(op_a) >>> w_shamt);
         c_OR:   w_alu = op_a | op_b;
         c_AND:  w_alu = op_a & op_b;
         c_EQ:   w_alu = {{(XLEN-1){1'b0}}, (op_a == op_b)};
         c_NE:   w_alu = {{(XLEN-1){1'b0}}, (op_a != op_b)};
         c_LT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         c_GE:   w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) >= $signed(op_b))};
         c_LTU:  w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: w_alu = {{(XLEN-1){1'b0}}, (op_a >= op_b)};
      endcase
      if (w_illegal) begin
         w_alu = '0;
      end
   end

   assign w_taken    = !w_illegal && (w_sel >= c_EQ) && w_alu[0];
   assign w_is_shift = !w_illegal && (w_sel == c_SLL || w_sel == c_SRL || w_sel == c_SRA);
   assign w_serial   = SERIAL_SHIFT && w_is_shift && (w_shamt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid) w_state_next = w_serial ? S_SHIFT : S_DONE;
         S_SHIFT: if (r_cnt == c_ONE) w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result  <= '0;
         r_sel     <= c_ADD;
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_sel     <= w_sel;
         r_taken   <= w_taken;
         r_illegal <= w_illegal;
         r_result  <= w_alu;
         r_cnt     <= w_serial ? w_shamt : '0;
      end else if (r_state == S_SHIFT) begin
         r_cnt <= r_cnt - c_ONE;
         unique case (r_sel)
            c_SLL:   r_result <= {r_result[XLEN-2:0], 1'b0};
            c_SRA:   r_result <= {r_result[XLEN-1], r_result[XLEN-1:1]};
            default: r_result <= {1'b0, r_result[XLEN-1:1]};
         endcase
      end
   end

   assign in_ready     = (r_state == S_IDLE);
   assign out_valid    = (r_state == S_DONE);
   assign result       = r_result;
   assign sel_alu      = r_sel;
   assign branch_taken = r_taken;
   assign illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_exec
// Description : Scoreboard bench for alu_ctrl_exec (XLEN=32, serial shifts).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_exec;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      modo;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic [3:0]      sel_alu;
   logic            branch_taken;
   logic            illegal;

   alu_ctrl_exec #(.XLEN(XLEN), .SERIAL_SHIFT(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .modo(modo), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .sel_alu(sel_alu), .branch_taken(branch_taken), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  sel;
      logic        tk;
      logic        ill;
      logic [7:0]  lat;
   } exp_t;

   typedef struct packed {
      logic [1:0]  m;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference behaviour used for the random traffic
   function automatic exp_t model(input vec_t v);
      exp_t e;
      int   s;
      logic [4:0] sh;
      e  = '0;
      sh = v.b[4:0];
      s  = 0;
      if (v.m == 2'd0) s = 0;
      else if (v.m == 2'd3) begin
         case (v.f3)
            3'd0: s = 10;  3'd1: s = 11;  3'd4: s = 12;
            3'd5: s = 13;  3'd6: s = 14;  3'd7: s = 15;
            default: s = -1;
         endcase
      end else if (v.m == 2'd2 && v.f7[5] && v.f3 != 3'd0 && v.f3 != 3'd5) s = -1;
      else begin
         case (v.f3)
            3'd0: s = (v.m == 2'd2 && v.f7[5]) ? 1 : 0;
            3'd1: s = 2;  3'd2: s = 3;  3'd3: s = 4;  3'd4: s = 5;
            3'd5: s = v.f7[5] ? 7 : 6;
            3'd6: s = 8;
            default: s = 9;
         endcase
      end
      e.lat = 8'd1;
      if (s < 0) begin
         e.ill = 1'b1;
         return e;
      end
      e.sel = s[3:0];
      case (s)
         0:  e.res = v.a + v.b;
         1:  e.res = v.a - v.b;
         2:  e.res = v.a << sh;
         3:  e.res = {31'd0, $signed(v.a) < $signed(v.b)};
         4:  e.res = {31'd0, v.a < v.b};
         5:  e.res = v.a ^ v.b;
         6:  e.res = v.a >> sh;
         7:  e.res = $signed(v.a) >>> sh;
         8:  e.res = v.a | v.b;
         9:  e.res = v.a & v.b;
         10: e.res = {31'd0, v.a == v.b};
         11: e.res = {31'd0, v.a != v.b};
         12: e.res = {31'd0, $signed(v.a) < $signed(v.b)};
         13: e.res = {31'd0, $signed(v.a) >= $signed(v.b)};
         14: e.res = {31'd0, v.a < v.b};
         default: e.res = {31'd0, v.a >= v.b};
      endcase
      if (s >= 10) e.tk = e.res[0];
      if ((s == 2 || s == 6 || s == 7) && sh != 5'd0) e.lat = {3'd0, sh} + 8'd1;
      return e;
   endfunction

   // Offer one operation, then scramble the inputs to show they are ignored
   task automatic send(input vec_t v);
      @(negedge clk);
      modo = v.m; funct3 = v.f3; funct7 = v.f7; op_a = v.a; op_b = v.b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      modo = 2'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      op_a = $urandom; op_b = $urandom;
   endtask

   task automatic wait_out(output int lat, output bit rdy_seen);
      lat = 0;
      rdy_seen = 1'b0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (in_ready) rdy_seen = 1'b1;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, result, sel_alu, branch_taken, illegal} !== {1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset: got rdy=%b ov=%b res=%h sel=%0d tk=%b ill=%b, want rdy=1 ov=0 res=0 sel=0 tk=0 ill=0",
                  in_ready, out_valid, result, sel_alu, branch_taken, illegal);
      end
   endtask

   task automatic test_alu();
      vec_t tbl [9];
      exp_t e, o;
      int   lat;
      bit   rdy;
      tbl[0] = {2'd0, 3'd0, 7'h00, 32'd5,          32'd7,          32'd12,         4'd0, 1'b0, 1'b0, 8'd1};
      tbl[1] = {2'd0, 3'd7, 7'h7f, 32'hffffffff,   32'd1,          32'd0,          4'd0, 1'b0, 1'b0, 8'd1};
      tbl[2] = {2'd1, 3'd0, 7'h20, 32'd10,         32'hfffffffd,   32'd7,          4'd0, 1'b0, 1'b0, 8'd1};
      tbl[3] = {2'd1, 3'd4, 7'h20, 32'h000000ff,   32'h0000000f,   32'h000000f0,   4'd5, 1'b0, 1'b0, 8'd1};
      tbl[4] = {2'd2, 3'd4, 7'h00, 32'h0000f0f0,   32'h00000ff0,   32'h0000ff00,   4'd5, 1'b0, 1'b0, 8'd1};
      tbl[5] = {2'd2, 3'd7, 7'h00, 32'h0000f0f0,   32'h00000ff0,   32'h000000f0,   4'd9, 1'b0, 1'b0, 8'd1};
      tbl[6] = {2'd1, 3'd6, 7'h00, 32'h0000f0f0,   32'h00000ff0,   32'h0000fff0,   4'd8, 1'b0, 1'b0, 8'd1};
      tbl[7] = {2'd2, 3'd2, 7'h00, 32'hffffffff,   32'd1,          32'd1,          4'd3, 1'b0, 1'b0, 8'd1};
      tbl[8] = {2'd2, 3'd3, 7'h00, 32'hffffffff,   32'd1,          32'd0,          4'd4, 1'b0, 1'b0, 8'd1};
      for (int i = 0; i < 9; i++) begin
         sb.push_back(tbl[i].e);
         send(tbl[i]);
         wait_out(lat, rdy);
         e = sb.pop_front();
         o = {result, sel_alu, branch_taken, illegal, 8'(lat)};
         n_vec++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL alu[%0d]: got res=%h sel=%0d tk=%b ill=%b lat=%0d, want res=%h sel=%0d tk=%b ill=%b lat=%0d",
                     i, o.res, o.sel, o.tk, o.ill, o.lat, e.res, e.sel, e.tk, e.ill, e.lat);
         end
         consume();
      end
   endtask

   task automatic test_sub_hold();
      vec_t v;
      exp_t e, o;
      int   lat;
      bit   rdy;
      v = {2'd2, 3'd0, 7'h20, 32'd3, 32'd5, 32'hfffffffe, 4'd1, 1'b0, 1'b0, 8'd1};
      sb.push_back(v.e);
      send(v);
      wait_out(lat, rdy);
      e = sb.pop_front();
      o = {result, sel_alu, branch_taken, illegal, 8'(lat)};
      n_vec++;
      if (o !== e) begin
         n_bad++;
         $display("FAIL sub: got res=%h sel=%0d lat=%0d, want res=%h sel=%0d lat=%0d", o.res, o.sel, o.lat, e.res, e.sel, e.lat);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if ({out_valid, in_ready, result, sel_alu, branch_taken, illegal} !== {1'b1, 1'b0, e.res, e.sel, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL hold[%0d]: got ov=%b rdy=%b res=%h sel=%0d, want ov=1 rdy=0 res=%h sel=%0d",
                     c, out_valid, in_ready, result, sel_alu, e.res, e.sel);
         end
      end
      consume();
   endtask

   task automatic test_shift();
      vec_t tbl [5];
      exp_t e, o;
      int   lat;
      bit   rdy;
      tbl[0] = {2'd1, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'hf8000000, 4'd7, 1'b0, 1'b0, 8'd5};
      tbl[1] = {2'd1, 3'd1, 7'h00, 32'h00001234, 32'd0,        32'h00001234, 4'd2, 1'b0, 1'b0, 8'd1};
      tbl[2] = {2'd2, 3'd5, 7'h00, 32'h80000000, 32'd31,       32'd1,        4'd6, 1'b0, 1'b0, 8'd32};
      tbl[3] = {2'd2, 3'd1, 7'h00, 32'd3,        32'hffffffe1, 32'd6,        4'd2, 1'b0, 1'b0, 8'd2};
      tbl[4] = {2'd1, 3'd5, 7'h20, 32'h40000000, 32'd2,        32'h10000000, 4'd7, 1'b0, 1'b0, 8'd3};
      for (int i = 0; i < 5; i++) begin
         sb.push_back(tbl[i].e);
         send(tbl[i]);
         wait_out(lat, rdy);
         e = sb.pop_front();
         o = {result, sel_alu, branch_taken, illegal, 8'(lat)};
         n_vec++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL shift[%0d]: got res=%h sel=%0d lat=%0d, want res=%h sel=%0d lat=%0d",
                     i, o.res, o.sel, o.lat, e.res, e.sel, e.lat);
         end
         n_vec++;
         if (rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL shift_busy[%0d]: in_ready seen 1 while busy, want 0", i);
         end
         consume();
      end
   endtask

   task automatic test_branch_illegal();
      vec_t tbl [10];
      exp_t e, o;
      int   lat;
      bit   rdy;
      tbl[0] = {2'd3, 3'd4, 7'h00, 32'hffffffff, 32'd1, 32'd1, 4'd12, 1'b1, 1'b0, 8'd1};
      tbl[1] = {2'd3, 3'd6, 7'h00, 32'hffffffff, 32'd1, 32'd0, 4'd14, 1'b0, 1'b0, 8'd1};
      tbl[2] = {2'd3, 3'd0, 7'h00, 32'd9,        32'd9, 32'd1, 4'd10, 1'b1, 1'b0, 8'd1};
      tbl[3] = {2'd3, 3'd1, 7'h00, 32'd9,        32'd9, 32'd0, 4'd11, 1'b0, 1'b0, 8'd1};
      tbl[4] = {2'd3, 3'd5, 7'h00, 32'hffffffff, 32'd1, 32'd0, 4'd13, 1'b0, 1'b0, 8'd1};
      tbl[5] = {2'd3, 3'd7, 7'h00, 32'hffffffff, 32'd1, 32'd1, 4'd15, 1'b1, 1'b0, 8'd1};
      tbl[6] = {2'd3, 3'd2, 7'h00, 32'd5,        32'd5, 32'd0, 4'd0,  1'b0, 1'b1, 8'd1};
      tbl[7] = {2'd3, 3'd3, 7'h00, 32'd5,        32'd5, 32'd0, 4'd0,  1'b0, 1'b1, 8'd1};
      tbl[8] = {2'd2, 3'd4, 7'h20, 32'd5,        32'd5, 32'd0, 4'd0,  1'b0, 1'b1, 8'd1};
      tbl[9] = {2'd2, 3'd1, 7'h20, 32'd5,        32'd1, 32'd0, 4'd0,  1'b0, 1'b1, 8'd1};
      for (int i = 0; i < 10; i++) begin
         sb.push_back(tbl[i].e);
         send(tbl[i]);
         wait_out(lat, rdy);
         e = sb.pop_front();
         o = {result, sel_alu, branch_taken, illegal, 8'(lat)};
         n_vec++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL br_ill[%0d]: got res=%h sel=%0d tk=%b ill=%b lat=%0d, want res=%h sel=%0d tk=%b ill=%b lat=%0d",
                     i, o.res, o.sel, o.tk, o.ill, o.lat, e.res, e.sel, e.tk, e.ill, e.lat);
         end
         consume();
      end
   endtask

   task automatic test_reset_mid_shift();
      vec_t v;
      exp_t e, o;
      int   lat;
      bit   rdy;
      v = {2'd2, 3'd5, 7'h00, 32'h0000ffff, 32'd20, 32'd0, 4'd6, 1'b0, 1'b0, 8'd21};
      send(v);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({out_valid, result} !== {1'b0, 32'd0}) begin
         n_bad++;
         $display("FAIL mid_rst: got ov=%b res=%h, want ov=0 res=0", out_valid, result);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL mid_rst_release: got rdy=%b ov=%b, want rdy=1 ov=0", in_ready, out_valid);
      end
      v = {2'd0, 3'd0, 7'h00, 32'd1, 32'd1, 32'd2, 4'd0, 1'b0, 1'b0, 8'd1};
      sb.push_back(v.e);
      send(v);
      wait_out(lat, rdy);
      e = sb.pop_front();
      o = {result, sel_alu, branch_taken, illegal, 8'(lat)};
      n_vec++;
      if (o !== e) begin
         n_bad++;
         $display("FAIL post_rst_add: got res=%h lat=%0d, want res=%h lat=%0d", o.res, o.lat, e.res, e.lat);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      vec_t v;
      exp_t e, o;
      int   lat;
      bit   rdy;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         v.m  = 2'($urandom);
         v.f3 = 3'($urandom);
         v.f7 = 7'($urandom);
         v.a  = $urandom;
         v.b  = $urandom;
         v.e  = model(v);
         sb.push_back(v.e);
         send(v);
         wait_out(lat, rdy);
         e = sb.pop_front();
         o = {result, sel_alu, branch_taken, illegal, 8'(lat)};
         n_vec++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL b2b[%0d] m=%0d f3=%0d f7=%h a=%h b=%h: got res=%h sel=%0d tk=%b ill=%b lat=%0d, want res=%h sel=%0d tk=%b ill=%b lat=%0d",
                     i, v.m, v.f3, v.f7, v.a, v.b, o.res, o.sel, o.tk, o.ill, o.lat, e.res, e.sel, e.tk, e.ill, e.lat);
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      modo = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_alu();
      test_sub_hold();
      test_shift();
      test_branch_illegal();
      test_reset_mid_shift();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
